// File: rtl/irq_pending_collector.sv
// irq_pending_collector
// Front end of the 8-input highest-bit-wins interrupt path. Rising edges on
// req_in are captured into a sticky pending register. The masked view of that
// register is driven to the priority isolator on pending_out. The winning
// channel is locked and offered as a binary id on a valid/ready handshake.
// Acceptance clears the channel's pending bit. Edges that arrive while a
// channel is already pending are counted in a saturating drop counter.

module irq_pending_collector #(
  parameter  int N    = 8,
  parameter  int CNTW = 8,
  localparam int IDW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_in,
  input  logic [N-1:0]    mask,
  output logic [N-1:0]    pending_out,
  output logic            irq_valid,
  output logic [IDW-1:0]  irq_id,
  input  logic            irq_ready,
  output logic [CNTW-1:0] drop_cnt
);

  // Width that can hold a per-cycle drop count from 0 to N.
  localparam int INCW = IDW + 1;
  // Width of the unsaturated drop sum. It cannot overflow before the
  // saturation check is applied.
  localparam int SUMW = CNTW + INCW;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N-1:0]    req_q,       req_d;
  logic [N-1:0]    pending_q,   pending_d;
  state_t          state_q,     state_d;
  logic            irq_valid_q, irq_valid_d;
  logic [IDW-1:0]  irq_id_q,    irq_id_d;
  logic [CNTW-1:0] drop_cnt_q,  drop_cnt_d;

  // ---------------------------------------------------------------------------
  // Per-channel combinational terms
  // ---------------------------------------------------------------------------
  logic [N-1:0]    rise;        // rising edge seen on req_in this cycle
  logic [N-1:0]    accept_hit;  // channel whose offer is accepted this cycle
  logic [N-1:0]    drop_hit;    // edge lost because channel already pending
  logic            handshake;   // offer accepted this cycle
  logic [INCW-1:0] drop_inc;    // number of edges lost this cycle
  logic [SUMW-1:0] drop_sum;    // unsaturated next drop count
  logic [IDW-1:0]  sel_id;      // highest set bit of pending_out
  logic            any_visible; // something unmasked is pending

  // req_q holds last cycle's request lines. After reset it holds zero, so a
  // line that is already high when reset releases counts as one edge.
  assign req_d     = req_in;
  assign rise      = req_in & ~req_q;
  assign handshake = irq_valid_q & irq_ready;

  // Per-channel pending update. A new edge always sets the bit, even on the
  // channel being accepted, so the request is not lost. The edge only counts
  // as a drop when the bit stays pending and is not consumed this cycle.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign accept_hit[gi] = handshake && (irq_id_q == IDW'(gi));
      assign drop_hit[gi]   = rise[gi] & pending_q[gi] & ~accept_hit[gi];
      assign pending_d[gi]  = rise[gi] ? 1'b1
                            : (accept_hit[gi] ? 1'b0 : pending_q[gi]);
    end
  endgenerate

  // Masked view handed to the isolator. It is driven directly from registers
  // so that a reset assertion clears it immediately.
  assign pending_out = pending_q & ~mask;
  assign any_visible = |pending_out;

  // Population count of lost edges this cycle.
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < N; i++) begin
      drop_inc = drop_inc + INCW'(drop_hit[i]);
    end
  end

  // Saturating accumulate. The counter sticks at all-ones and never wraps.
  always_comb begin
    drop_sum = {{INCW{1'b0}}, drop_cnt_q} + {{CNTW{1'b0}}, drop_inc};
    if (|drop_sum[SUMW-1:CNTW]) begin
      drop_cnt_d = {CNTW{1'b1}};
    end else begin
      drop_cnt_d = drop_sum[CNTW-1:0];
    end
  end

  // Highest-index-wins selection over the unmasked pending bits.
  always_comb begin
    sel_id = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_out[i]) begin
        sel_id = IDW'(i);
      end
    end
  end

  // Offer FSM next-state logic. IDLE loads the winner and raises valid.
  // OFFER holds id/valid stable until acceptance, with no preemption and no
  // withdrawal on mask changes. Acceptance returns to IDLE with valid low,
  // which guarantees a bubble cycle between offers.
  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    case (state_q)
      IDLE: begin
        if (any_visible) begin
          state_d     = OFFER;
          irq_valid_d = 1'b1;
          irq_id_d    = sel_id;
        end else begin
          irq_valid_d = 1'b0;
        end
      end
      OFFER: begin
        if (irq_ready) begin
          state_d     = IDLE;
          irq_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        irq_valid_d = 1'b0;
      end
    endcase
  end

  // All state registers. The asynchronous reset clears everything at once,
  // including any offer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      pending_q   <= '0;
      state_q     <= IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      req_q       <= req_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_irq_pending_collector.sv
// Scoreboard testbench for irq_pending_collector.
// The stimulus task predicts the visible outputs for each cycle from a
// behavioural model. It pushes the expected per-cycle status and every
// expected handshake id into queues. A monitor on the falling edge pops the
// queues and compares them with the DUT outputs.

module tb_irq_pending_collector;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic [7:0] pending_out;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic       irq_ready;
  logic [7:0] drop_cnt;

  irq_pending_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_in      (req_in),
    .mask        (mask),
    .pending_out (pending_out),
    .irq_valid   (irq_valid),
    .irq_id      (irq_id),
    .irq_ready   (irq_ready),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] id;
    logic [7:0] po;
    logic [7:0] dc;
  } exp_t;

  exp_t status_q[$];
  int   hs_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;

  // Behavioural model: a set of pending channels, an optional current offer,
  // the previous request levels and a drop tally.
  logic [7:0] m_pend;
  logic [7:0] m_prev;
  logic       m_off;
  int         m_id;
  int         m_drop;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_pend = 8'h00;
    m_prev = 8'h00;
    m_off  = 1'b0;
    m_id   = 0;
    m_drop = 0;
  endfunction

  // One clock of the specification's rules, applied to inputs r/m/rd.
  function automatic void model_clock(logic [7:0] r, logic [7:0] m, logic rd);
    logic [7:0] nxt;
    logic [7:0] vis;
    bit         accept;
    int         lost;
    accept = m_off && rd;
    nxt    = m_pend;
    lost   = 0;
    for (int i = 0; i < 8; i++) begin
      if (r[i] && !m_prev[i]) begin
        if (m_pend[i] && !(accept && m_id == i)) lost++;
        nxt[i] = 1'b1;
      end else if (accept && m_id == i) begin
        nxt[i] = 1'b0;
      end
    end
    m_drop = (m_drop + lost > 255) ? 255 : m_drop + lost;
    if (m_off) begin
      if (rd) m_off = 1'b0;
    end else begin
      vis = m_pend & ~m;
      if (vis != 8'h00) begin
        m_off = 1'b1;
        for (int i = 0; i < 8; i++) if (vis[i]) m_id = i;
      end
    end
    m_pend = nxt;
    m_prev = r;
  endfunction

  // Drive one cycle: predict the outputs visible now, then advance the model.
  task automatic step(input logic [7:0] r, input logic [7:0] m, input logic rd);
    exp_t e;
    req_in    = r;
    mask      = m;
    irq_ready = rd;
    e.v  = m_off;
    e.id = 3'(m_id);
    e.po = m_pend & ~m;
    e.dc = 8'(m_drop);
    status_q.push_back(e);
    if (m_off && rd) hs_q.push_back(m_id);
    model_clock(r, m, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    req_in    = 8'h00;
    mask      = 8'h00;
    irq_ready = 1'b0;
    chk("hs_leftover", hs_q.size(), 0);
    status_q.delete();
    hs_q.delete();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: one status record per cycle, one id per observed handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (status_q.size() == 0) begin
        chk("status_underflow", 1, 0);
      end else begin
        e = status_q.pop_front();
        chk("irq_valid", int'(irq_valid), int'(e.v));
        if (e.v) chk("irq_id", int'(irq_id), int'(e.id));
        chk("pending_out", int'(pending_out), int'(e.po));
        chk("drop_cnt", int'(drop_cnt), int'(e.dc));
      end
      if (irq_valid && irq_ready) begin
        if (hs_q.size() == 0) begin
          chk("hs_unexpected", int'(irq_id), -1);
        end else begin
          chk("hs_id", int'(irq_id), hs_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_in    = 8'h00;
    mask      = 8'h00;
    irq_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", int'(irq_valid), 0);
    chk("rst_id", int'(irq_id), 0);
    chk("rst_pending_out", int'(pending_out), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    do_reset();

    // Single pulse on ch2, ready held high.
    step(8'h04, 8'h00, 1'b1);
    repeat (4) step(8'h00, 8'h00, 1'b1);
    chk("t1_pending_out", int'(pending_out), 0);
    chk("t1_drop", int'(drop_cnt), 0);

    // Two channels at once: id 7, bubble, then id 0.
    step(8'h81, 8'h00, 1'b1);
    repeat (6) step(8'h00, 8'h00, 1'b1);

    // Stall on id 1 while ch6 arrives; no preemption.
    do_reset();
    step(8'h02, 8'h00, 1'b0);
    repeat (2) step(8'h00, 8'h00, 1'b0);
    step(8'h40, 8'h00, 1'b0);
    repeat (2) step(8'h00, 8'h00, 1'b0);
    chk("stall_valid", int'(irq_valid), 1);
    chk("stall_id", int'(irq_id), 1);
    step(8'h00, 8'h00, 1'b1);
    repeat (4) step(8'h00, 8'h00, 1'b1);

    // Masked channels stay pending and are offered once unmasked.
    do_reset();
    step(8'h30, 8'hF0, 1'b1);
    repeat (3) step(8'h00, 8'hF0, 1'b1);
    chk("mask_valid", int'(irq_valid), 0);
    chk("mask_pending_out", int'(pending_out), 0);
    repeat (6) step(8'h00, 8'h00, 1'b1);

    // Three pulses on ch3 while stalled: two drops.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(8'h08, 8'h00, 1'b0);
      step(8'h00, 8'h00, 1'b0);
    end
    step(8'h00, 8'h00, 1'b0);
    chk("drop_two", int'(drop_cnt), 2);

    // Saturation: all channels masked and pending, toggled repeatedly.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step(8'hFF, 8'hFF, 1'b0);
      step(8'h00, 8'hFF, 1'b0);
    end
    step(8'h00, 8'hFF, 1'b0);
    chk("drop_sat", int'(drop_cnt), 255);

    // Asynchronous reset in the middle of an offer of id 7.
    do_reset();
    step(8'h80, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    step(8'h80, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    chk("pre_rst_valid", int'(irq_valid), 1);
    chk("pre_rst_id", int'(irq_id), 7);
    chk("pre_rst_drop", int'(drop_cnt), 1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", int'(irq_valid), 0);
    chk("async_pending_out", int'(pending_out), 0);
    chk("async_drop", int'(drop_cnt), 0);
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      logic [7:0] r;
      logic [7:0] m;
      r = 8'($urandom & $urandom & $urandom);
      m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(r, m, 1'($urandom_range(0, 1)));
    end
    repeat (20) step(8'h00, 8'h00, 1'b1);

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_pending_collector.md
Name: irq_pending_collector

Overview:
- Upstream stage of the 8-input highest-bit-wins priority isolator.
- Captures rising-edge requests into a sticky pending register and applies a mask.
- Drives `pending_out` into the isolator.
- Locks the winning channel and offers its binary id on a valid/ready handshake to the consumer, clearing that channel's pending bit on acceptance.

Parameters:
- N, 8, number of request channels; highest index = highest priority.
- IDW, $clog2(N) = 3, width of `irq_id`; derived, not overridden.
- CNTW, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset; asserted low clears all state immediately, released synchronously by the integrator.
- req_in  input  N  per-channel request lines, synchronous to `clk`; edge-sensitive.
- mask  input  N  1 = channel excluded from selection; pending bit still set and retained.
- pending_out  output  N  pending & ~mask, combinational from registers; feeds the priority isolator.
- irq_valid  output  1  an id is offered.
- irq_id  output  IDW  binary index of the offered channel.
- irq_ready  input  1  consumer accepts the offer when high with `irq_valid`.
- drop_cnt  output  CNTW  saturating count of requests lost because the channel was already pending.

Behaviour:
Reset values:
- `req_q` = 0, `pending` = 0, state = IDLE.
- `irq_valid` = 0, `irq_id` = 0, `drop_cnt` = 0, hence `pending_out` = 0.

Edge detect:
- `req_q` <= `req_in` each cycle; `rise` = `req_in` & ~`req_q`.
- A line already high when reset releases counts as one edge on the first clock.

Pending register, per bit i, next value:
- 1 if `rise[i]`.
- else 0 if the handshake (`irq_valid` & `irq_ready`) accepts id i this cycle.
- else unchanged.
- Set wins over clear: a rise on the channel being accepted in the same cycle re-pends it and is not counted as a drop.

Drop counter:
- Increments by the number of channels with `rise[i]` & `pending[i]` where i is not being accepted this cycle.
- Saturates at 2^CNTW-1; never wraps.

FSM with states IDLE and OFFER:
- IDLE: if |`pending_out` -> load `irq_id` = index of the highest set bit of `pending_out`, set `irq_valid` = 1, go to OFFER. Otherwise stay, `irq_valid` = 0.
- OFFER, `irq_ready` = 0: hold `irq_id` and `irq_valid` stable. No preemption by higher-priority arrivals. Mask changes do not withdraw the offer.
- OFFER, `irq_ready` = 1: handshake completes; `pending[irq_id]` cleared per the rule above; `irq_valid` = 0 next cycle; go to IDLE.
- At least one bubble cycle between consecutive offers.

Latency:
- `req_in` rises before edge t -> `pending` set at edge t -> `irq_valid` high after edge t+1, if the channel is unmasked and the FSM is in IDLE.

Boundary conditions:
- Masked pending channels stay pending and are offered after unmasking, with no re-edge needed.
- All channels masked: stays in IDLE, `irq_valid` = 0.
- A level held high produces one pending event only.
- Reset asserted mid-offer: `irq_valid` drops asynchronously and all pending bits are lost.
- `irq_ready` high while `irq_valid` is low has no effect.

Test Plan:
- Reset, then pulse `req_in` = 8'h04 for one cycle, `irq_ready` = 1 -> `irq_valid` high 2 cycles after the pulse, `irq_id` = 2 for one cycle, then `pending_out` = 0 and `drop_cnt` = 0.
- Pulse `req_in` = 8'h81 together, `irq_ready` = 1 -> offers id 7, one bubble cycle, then id 0; `pending_out` goes 8'h81 -> 8'h01 -> 8'h00.
- Pulse ch1, `irq_ready` = 0 until the offer appears; then pulse ch6 -> `irq_id` stays 1 while stalled; after accepting id 1, the next offer is id 6.
- Set `mask` = 8'hF0, pulse 8'h30 -> `irq_valid` stays 0 and `pending_out` = 0; clear `mask` -> offers id 5, then id 4.
- Pulse ch3 three times with `irq_ready` = 0 -> `drop_cnt` = 2. Separately, force 300 drops -> `drop_cnt` = 255.
- During OFFER with `irq_id` = 7, assert `rst_n` = 0 mid-cycle -> `irq_valid`, `pending_out` and `drop_cnt` go to 0 immediately, before the next clock edge.
